// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: branch flush, jump redirect,
// load-use replay, mult/div stall FSM and a saturating lost-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_valid,
  input  logic             id_jump,
  input  logic             id_md_start,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             valid_PC,
  output logic             flush,
  output logic             id_ex_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_JUMP   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;
  localparam logic [1:0] SEL_REPLAY = 2'b11;

  state_e           state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             lu;
  logic             lost_cycle;

  assign lu = ex_mem_read && id_valid && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // NOTE: every output and next-state value gets a default first, so no
  // path through the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_write     = 1'b1;
    pc_sel       = SEL_SEQ;
    valid_PC     = 1'b1;
    flush        = 1'b0;
    id_ex_bubble = 1'b0;
    md_busy      = 1'b0;

    if (!rst_n) begin
      // Reset fills the pipe with NOPs without waiting for a clock edge.
      pc_write     = 1'b0;
      valid_PC     = 1'b0;
      flush        = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            pc_sel       = SEL_BRANCH;
            flush        = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (lu) begin
            pc_sel       = SEL_REPLAY;
            valid_PC     = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_jump) begin
            pc_sel   = SEL_JUMP;
            valid_PC = 1'b0;
          end else if (id_md_start) begin
            pc_write = 1'b0;
            valid_PC = 1'b0;
            state_d  = MD_WAIT;
            md_cnt_d = 4'(MD_LATENCY);
          end
        end
        MD_WAIT: begin
          pc_write     = 1'b0;
          valid_PC     = 1'b0;
          id_ex_bubble = 1'b1;
          md_busy      = 1'b1;
          md_cnt_d     = md_cnt_q - 4'd1;
          // Exit on 0 as well so a corrupted count can never lock the core.
          if (md_cnt_q <= 4'd1) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign lost_cycle = !pc_write || flush || (pc_sel == SEL_REPLAY);

  always_comb begin
    stall_count_d = stall_count_q;
    if (lost_cycle && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its sources, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      md_cnt_q      <= 4'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed vectors, immediate assertions,
// plus a narrow-counter instance sharing the stimulus for saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_valid, id_jump, id_md_start;
  logic        ex_mem_read, ex_branch_taken;

  logic        pc_write, valid_PC, flush, id_ex_bubble, md_busy;
  logic [1:0]  pc_sel;
  logic [15:0] stall_count;

  logic        s_pc_write, s_valid_PC, s_flush, s_id_ex_bubble, s_md_busy;
  logic [1:0]  s_pc_sel;
  logic [3:0]  s_stall_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_valid(id_valid),
    .id_jump(id_jump), .id_md_start(id_md_start),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .pc_sel(pc_sel), .valid_PC(valid_PC), .flush(flush),
    .id_ex_bubble(id_ex_bubble), .md_busy(md_busy), .stall_count(stall_count)
  );

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_valid(id_valid),
    .id_jump(id_jump), .id_md_start(id_md_start),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(s_pc_write), .pc_sel(s_pc_sel), .valid_PC(s_valid_PC), .flush(s_flush),
    .id_ex_bubble(s_id_ex_bubble), .md_busy(s_md_busy), .stall_count(s_stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the six control outputs of the main instance.
  task automatic check_ctl(input string tag, input logic pw, input logic [1:0] sel,
                           input logic vpc, input logic fl, input logic bub, input logic busy);
    check({tag, ".pc_write"},     32'(pc_write),     32'(pw));
    check({tag, ".pc_sel"},       32'(pc_sel),       32'(sel));
    check({tag, ".valid_PC"},     32'(valid_PC),     32'(vpc));
    check({tag, ".flush"},        32'(flush),        32'(fl));
    check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(bub));
    check({tag, ".md_busy"},      32'(md_busy),      32'(busy));
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_valid = 1'b0; id_jump = 1'b0; id_md_start = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset with random inputs for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      id_rs = 5'($urandom); id_rt = 5'($urandom); ex_rt = 5'($urandom);
      {id_uses_rt, id_valid, id_jump, id_md_start, ex_mem_read, ex_branch_taken} = 6'($urandom);
      #1;
      check_ctl("rst", 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      check("rst.stall_count", 32'(stall_count), 32'd0);
      tick();
    end

    idle();
    rst_n = 1'b1;
    #1;
    check_ctl("rel", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Load-use via rs.
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_valid = 1'b1;
    #1;
    check_ctl("lu_rs", 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    check_ctl("lu_after", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu.stall_count", 32'(stall_count), 32'd1);

    // No false load-use: ex_rt = 0.
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_valid = 1'b1;
    #1;
    check_ctl("nolu_r0", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // No false load-use: rt matches but is not a source.
    ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    check_ctl("nolu_rt", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // No false load-use: ID holds a NOP.
    id_rs = 5'd7; id_valid = 1'b0;
    #1;
    check_ctl("nolu_nop", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Load-use via rt when rt is a source.
    id_rs = 5'd3; id_valid = 1'b1; id_uses_rt = 1'b1;
    #1;
    check_ctl("lu_rt", 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    check("lu_rt.stall_count", 32'(stall_count), 32'd2);

    // Jump: redirect, no lost-cycle count.
    id_jump = 1'b1; id_valid = 1'b1;
    #1;
    check_ctl("jump", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    check("jump.stall_count", 32'(stall_count), 32'd2);

    // Branch beats load-use, jump and mult/div.
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    id_valid = 1'b1; id_jump = 1'b1; id_md_start = 1'b1;
    #1;
    check("br.pc_sel",       32'(pc_sel),       32'h2);
    check("br.flush",        32'(flush),        32'd1);
    check("br.id_ex_bubble", 32'(id_ex_bubble), 32'd1);
    check("br.pc_write",     32'(pc_write),     32'd1);
    tick();
    idle();
    #1;
    check_ctl("br_after", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("br.stall_count", 32'(stall_count), 32'd3);

    // Mult/div: entry cycle, 4 wait cycles, then RUN.
    id_md_start = 1'b1; id_valid = 1'b1;
    #1;
    check_ctl("md_entry", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      // Inputs in MD_WAIT must be ignored.
      idle();
      ex_branch_taken = 1'(i % 2);
      id_jump = 1'b1;
      #1;
      check_ctl($sformatf("md_wait%0d", i), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    tick();
    idle();
    #1;
    check_ctl("md_done", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("md.stall_count", 32'(stall_count), 32'd8);

    // Reset during the 2nd MD_WAIT cycle.
    id_md_start = 1'b1; id_valid = 1'b1;
    tick();
    idle();
    tick();
    #1;
    check("mdrst.busy_before", 32'(md_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_ctl("mdrst_in", 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("mdrst.stall_count", 32'(stall_count), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_ctl("mdrst_rel", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    check_ctl("mdrst_run", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mdrst.stall_count2", 32'(stall_count), 32'd0);
    check("sat.start", 32'(s_stall_count), 32'd0);

    // 20 lost cycles: narrow counter saturates, wide one counts on.
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    idle();
    #1;
    check("sat.narrow", 32'(s_stall_count), 32'd15);
    check("sat.wide",   32'(stall_count),   32'd20);
    tick();
    #1;
    check("sat.hold", 32'(s_stall_count), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core with 8-bit PC. It drives the IF/ID register's `valid_PC` and `flush` inputs, the PC register's write enable and next-PC select, and the ID/EX bubble. It resolves three hazard classes: taken-branch flushes, jumps, and load-use replays. It also runs a multi-cycle stall FSM for mult/div instructions and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- `MD_LATENCY`, default 4: number of stall cycles after a mult/div leaves ID. Legal range 1..15.
- `CNT_W`, default 16: width of `stall_count`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_rs`  in  5  rs field of the instruction in ID.
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rt`  in  1  the ID instruction reads rt as a source.
- `id_valid`  in  1  the ID instruction is not a NOP.
- `id_jump`  in  1  the ID instruction is an unconditional jump.
- `id_md_start`  in  1  the ID instruction is mult/div.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_rt`  in  5  destination register of the EX load.
- `ex_branch_taken`  in  1  a branch resolved taken in EX.
- `pc_write`  out  1  PC register load enable.
- `pc_sel`  out  2  next-PC select: 00 = PC+1, 01 = jump target, 10 = branch target, 11 = replay (PC of the ID instruction).
- `valid_PC`  out  1  to IF/ID; 0 loads a NOP.
- `flush`  out  1  to IF/ID; 1 loads a NOP.
- `id_ex_bubble`  out  1  forces the ID/EX register to a NOP.
- `md_busy`  out  1  high while in MD_WAIT.
- `stall_count`  out  CNT_W  saturating count of lost cycles.

## Operation
- State: `state` ∈ {RUN, MD_WAIT}, plus `md_cnt` (4 bits) and `stall_count`. All are registered. The control outputs are combinational from the state and the inputs.
- Default outputs in RUN with no event: `pc_write`=1, `pc_sel`=00, `valid_PC`=1, `flush`=0, `id_ex_bubble`=0, `md_busy`=0.
- The load-use condition `lu` is true when all of the following hold:
  - `ex_mem_read`, `id_valid`, and `ex_rt`≠0;
  - `ex_rt`==`id_rs`, or (`id_uses_rt` and `ex_rt`==`id_rt`).
- Events in RUN are handled in this priority order; exactly one applies per cycle:
  1. **`ex_branch_taken`**: `pc_sel`=10, `flush`=1, `id_ex_bubble`=1. `lu`, jump and md in ID are discarded.
  2. **`lu`**: `pc_sel`=11, `pc_write`=1, `valid_PC`=0, `id_ex_bubble`=1. The ID instruction is refetched.
  3. **`id_jump`**: `pc_sel`=01, `valid_PC`=0. The jump itself proceeds to EX.
  4. **`id_md_start`**: `pc_write`=0 and `valid_PC`=0 (the fetched successor is dropped and the PC holds at it). The md instruction proceeds to EX. Next state MD_WAIT with `md_cnt`←`MD_LATENCY`.
- **MD_WAIT**: `pc_write`=0, `valid_PC`=0, `id_ex_bubble`=1, `md_busy`=1, and `md_cnt` decrements each cycle. When `md_cnt`==1, next state is RUN. All other inputs are ignored in MD_WAIT; a branch cannot be in EX behind an md instruction.
- **`stall_count`**: increments by 1 in any cycle where `pc_write`=0, `flush`=1, or `pc_sel`=11, provided `rst_n`=1. It saturates at all-ones; no wrap.

## Timing
- While `rst_n`=0, asynchronously and regardless of the other inputs:
  - state=RUN, `md_cnt`=0, `stall_count`=0;
  - outputs forced to `pc_write`=0, `pc_sel`=00, `valid_PC`=0, `flush`=1, `id_ex_bubble`=1, `md_busy`=0, which fills the pipe with NOPs.
- Reset asserted mid-MD_WAIT: abort immediately. The first cycle after release is RUN with default outputs.
- Branch, load-use and jump responses are same-cycle (combinational) and last exactly one cycle.
- Load-use costs 2 cycles: the ID instruction re-enters ID 2 cycles later, with the load then in WB.
- md costs `MD_LATENCY`+1 lost fetch cycles: the entry cycle plus `MD_LATENCY` wait cycles. The first RUN cycle after MD_WAIT fetches the held PC.
- Simultaneous `ex_branch_taken` and `id_md_start`: the branch wins and MD_WAIT is not entered.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles with random inputs → `flush`=1, `pc_write`=0, `stall_count`=0. First cycle after release → `pc_write`=1, `pc_sel`=00, `valid_PC`=1.
- **Load-use**: `ex_mem_read`=1, `ex_rt`=5, `id_rs`=5, `id_valid`=1 → `pc_sel`=11, `valid_PC`=0, `id_ex_bubble`=1 for 1 cycle, `stall_count`=1.
- **No false load-use**: repeat the load-use stimulus with `ex_rt`=0, then with `ex_rt`=`id_rt`=7 and `id_uses_rt`=0 → default outputs in both cases.
- **Branch priority**: `ex_branch_taken`=1 together with `lu` and `id_md_start` all true → `pc_sel`=10, `flush`=1, `id_ex_bubble`=1; state remains RUN next cycle.
- **Mult/div**: `id_md_start`=1 with `MD_LATENCY`=4 → 1 entry cycle (`pc_write`=0, `id_ex_bubble`=0), then exactly 4 cycles with `md_busy`=1, then RUN; `stall_count`=5.
- **Reset mid-wait and saturation**: assert `rst_n`=0 during the 2nd MD_WAIT cycle → `md_busy` falls immediately and RUN follows release. Separately, with `CNT_W`=4, force 20 lost cycles → `stall_count`=15.
